// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// States are plain localparam codes so legacy tools can consume them.
package fetch_pkg;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_REQ    = 3'd0;
  localparam fetch_state_t ST_WAIT   = 3'd1;
  localparam fetch_state_t ST_HOLD   = 3'd2;
  localparam fetch_state_t ST_HALTED = 3'd3;
  localparam fetch_state_t ST_FAULT  = 3'd4;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs the single-outstanding imem handshake
// and latches the fetched word until the core retires it.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCnext,
  input  logic        Halt,
  input  logic        inst_ready,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  output logic [31:0] PCaddress,
  output logic [31:0] PCincre,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] retire_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  cnt_q, cnt_d;

  logic is_req, is_wait, is_hold;
  logic is_halt, is_fault;
  logic retire;

  assign is_req   = (state_q == ST_REQ);
  assign is_wait  = (state_q == ST_WAIT);
  assign is_hold  = (state_q == ST_HOLD);
  assign is_halt  = (state_q == ST_HALTED);
  assign is_fault = (state_q == ST_FAULT);
  assign retire   = is_hold & inst_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      is_req: begin
        if (imem_req_ready) state_d = ST_WAIT;
      end
      is_wait: begin
        if (imem_resp_valid) begin
          inst_d  = imem_resp_data;
          state_d = ST_HOLD;
        end
      end
      is_hold: begin
        if (retire) begin
          cnt_d = cnt_q + 32'd1;
          pc_d  = PCnext;
          // Misalignment wins over a simultaneous halt request
          if (|PCnext[1:0])  state_d = ST_FAULT;
          else if (Halt)     state_d = ST_HALTED;
          else               state_d = ST_REQ;
        end
      end
      is_halt, is_fault: ;
      default: state_d = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_valid = is_req & rst_n;
  assign imem_addr      = pc_q;
  assign PCaddress      = pc_q;
  assign PCincre        = pc_q + PC_STEP;
  assign inst           = inst_q;
  assign inst_valid     = is_hold;
  assign halted         = is_halt;
  assign fetch_fault    = is_fault;
  assign retire_count   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit.
// Inputs are applied after posedge, outputs compared on negedge.
module tb_fetch_unit;

  typedef struct {
    logic        rr;
    logic        rsv;
    logic [31:0] rd;
    logic        ir;
    logic [31:0] pn;
    logic        h;
  } in_t;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic [31:0] incre;
    logic [31:0] inst;
    logic        iv;
    logic        hl;
    logic        ft;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PCnext = 32'h0;
  logic        Halt = 1'b0;
  logic        inst_ready = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic [31:0] PCaddress;
  logic [31:0] PCincre;
  logic [31:0] inst;
  logic        inst_valid;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0050_0093;
  localparam logic [31:0] I2  = 32'h0010_0113;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .PCnext          (PCnext),
    .Halt            (Halt),
    .inst_ready      (inst_ready),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_req_valid  (imem_req_valid),
    .imem_addr       (imem_addr),
    .PCaddress       (PCaddress),
    .PCincre         (PCincre),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .halted          (halted),
    .fetch_fault     (fetch_fault),
    .retire_count    (retire_count)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(logic rr, logic rsv,
                             logic [31:0] rd, logic ir,
                             logic [31:0] pn, logic h);
    in_t r;
    r.rr = rr; r.rsv = rsv; r.rd = rd;
    r.ir = ir; r.pn = pn; r.h = h;
    return r;
  endfunction

  function automatic exp_t me(logic rv, logic [31:0] addr,
                              logic [31:0] incre,
                              logic [31:0] ins, logic iv,
                              logic hl, logic ft,
                              logic [31:0] cnt);
    exp_t r;
    r.rv = rv; r.addr = addr; r.incre = incre;
    r.inst = ins; r.iv = iv; r.hl = hl;
    r.ft = ft; r.cnt = cnt;
    return r;
  endfunction

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic chk(string tag, exp_t e);
    cmp({tag, ".req_valid"}, {31'd0, imem_req_valid},
        {31'd0, e.rv});
    cmp({tag, ".imem_addr"}, imem_addr, e.addr);
    cmp({tag, ".PCaddress"}, PCaddress, e.addr);
    cmp({tag, ".PCincre"}, PCincre, e.incre);
    cmp({tag, ".inst"}, inst, e.inst);
    cmp({tag, ".inst_valid"}, {31'd0, inst_valid},
        {31'd0, e.iv});
    cmp({tag, ".halted"}, {31'd0, halted}, {31'd0, e.hl});
    cmp({tag, ".fetch_fault"}, {31'd0, fetch_fault},
        {31'd0, e.ft});
    cmp({tag, ".retire_count"}, retire_count, e.cnt);
  endtask

  task automatic drive(in_t i);
    imem_req_ready  = i.rr;
    imem_resp_valid = i.rsv;
    imem_resp_data  = i.rd;
    inst_ready      = i.ir;
    PCnext          = i.pn;
    Halt            = i.h;
  endtask

  task automatic run(string tag, vec_t v);
    drive(v.i);
    @(negedge clk);
    chk(tag, v.e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mi(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst", me(1'b0, 32'h1000, 32'h1004, NOP,
                  1'b0, 1'b0, 1'b0, 32'd0));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[15];
  exp_t eh;

  initial begin
    // REQ stalled 3 cycles, accept, response, HOLD stalled 4
    tbl[0]  = '{mi(0,0,0,0,32'h1010,0),
                me(1,32'h1000,32'h1004,NOP,0,0,0,0)};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{mi(1,0,0,0,32'h1010,0),
                me(1,32'h1000,32'h1004,NOP,0,0,0,0)};
    tbl[4]  = '{mi(0,1,I1,0,32'h1010,0),
                me(0,32'h1000,32'h1004,NOP,0,0,0,0)};
    tbl[5]  = '{mi(0,0,BAD,0,32'h1010,0),
                me(0,32'h1000,32'h1004,I1,1,0,0,0)};
    tbl[6]  = tbl[5];
    tbl[7]  = tbl[5];
    tbl[8]  = tbl[5];
    tbl[9]  = '{mi(0,0,BAD,1,32'h1010,0),
                me(0,32'h1000,32'h1004,I1,1,0,0,0)};
    // response outside WAIT must be ignored
    tbl[10] = '{mi(1,1,BAD,0,32'h0,0),
                me(1,32'h1010,32'h1014,I1,0,0,0,1)};
    tbl[11] = '{mi(0,0,BAD,1,32'h0,0),
                me(0,32'h1010,32'h1014,I1,0,0,0,1)};
    tbl[12] = '{mi(0,1,I2,0,32'h0,0),
                me(0,32'h1010,32'h1014,I1,0,0,0,1)};
    tbl[13] = '{mi(1,0,0,1,32'h1010,1),
                me(0,32'h1010,32'h1014,I2,1,0,0,1)};
    tbl[14] = '{mi(1,1,BAD,1,32'h2000,0),
                me(0,32'h1010,32'h1014,I2,0,1,0,2)};

    do_reset();
    for (int k = 0; k < 15; k++)
      run($sformatf("vec%0d", k), tbl[k]);

    // HALTED must be sticky with PC frozen
    eh = me(0,32'h1010,32'h1014,I2,0,1,0,2);
    for (int k = 0; k < 20; k++)
      run("halted", '{mi(1,1,BAD,1,32'h3000,0), eh});

    // Misaligned PCnext beats Halt
    do_reset();
    run("f_req", '{mi(1,0,0,0,0,0),
        me(1,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("f_wait", '{mi(0,1,I1,0,0,0),
        me(0,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("f_hold", '{mi(0,0,0,1,32'h1002,1),
        me(0,32'h1000,32'h1004,I1,1,0,0,0)});
    for (int k = 0; k < 3; k++)
      run("fault", '{mi(1,1,BAD,1,32'h1000,0),
          me(0,32'h1002,32'h1006,I1,0,0,1,1)});

    // PCincre wraps at the top of the address space
    do_reset();
    run("w_req", '{mi(1,0,0,0,0,0),
        me(1,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("w_wait", '{mi(0,1,I2,0,0,0),
        me(0,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("w_hold", '{mi(0,0,0,1,32'hFFFF_FFFC,0),
        me(0,32'h1000,32'h1004,I2,1,0,0,0)});
    run("wrap", '{mi(0,0,0,0,0,0),
        me(1,32'hFFFF_FFFC,32'h0,I2,0,0,0,1)});

    // Reset in WAIT aborts; a late response is ignored
    do_reset();
    run("r_req", '{mi(1,0,0,0,0,0),
        me(1,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("r_wait", '{mi(0,1,I1,0,0,0),
        me(0,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("r_hold", '{mi(0,0,0,1,32'h1004,0),
        me(0,32'h1000,32'h1004,I1,1,0,0,0)});
    run("r_req2", '{mi(1,0,0,0,0,0),
        me(1,32'h1004,32'h1008,I1,0,0,0,1)});
    rst_n = 1'b0;
    #1;
    chk("r_abort", me(0,32'h1000,32'h1004,NOP,0,0,0,0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    run("r_late", '{mi(0,1,BAD,1,32'h2000,0),
        me(1,32'h1000,32'h1004,NOP,0,0,0,0)});
    run("r_idle", '{mi(0,0,0,1,32'h2000,0),
        me(1,32'h1000,32'h1004,NOP,0,0,0,0)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequential instruction-fetch stage that owns the architectural PC register and turns the combinational next-PC value into instruction-memory requests. It sits directly downstream of the next-PC mux: it supplies that mux with `PCaddress`/`PCincre` and consumes `PCnext` each time the core retires an instruction. It also runs the single-outstanding-request handshake with instruction memory and latches the fetched word for decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `PCnext`  in  32  next PC from the next-PC mux; sampled only at retire.
- `Halt`  in  1  halt request from decode, sampled only at retire.
- `inst_ready`  in  1  core accepts the presented instruction (retire).
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_resp_valid`  in  1  response data valid.
- `imem_resp_data`  in  32  fetched instruction word.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; equals `PCaddress`.
- `PCaddress`  out  32  current PC.
- `PCincre`  out  32  `PCaddress + 4`, modulo 2^32.
- `inst`  out  32  latched instruction.
- `inst_valid`  out  1  `inst` is valid for decode/execute.
- `halted`  out  1  core is halted.
- `fetch_fault`  out  1  misaligned next PC detected.
- `retire_count`  out  32  number of retired instructions, wraps.

## Operation
- FSM states: REQ, WAIT, HOLD, HALTED, FAULT. Outputs are Moore, decoded from the state and registers.
- REQ: `imem_req_valid`=1 and `imem_addr`=PC. If `imem_req_ready`=1, go to WAIT. Otherwise stay, holding address and valid stable.
- WAIT: on `imem_resp_valid`=1, latch `imem_resp_data` into `inst` and go to HOLD. `imem_resp_valid` outside WAIT is ignored.
- HOLD: `inst_valid`=1. Retire occurs when `inst_ready`=1 in HOLD. At retire:
  - `retire_count` increments.
  - PC loads `PCnext`.
  - If `PCnext[1:0]`≠0, go to FAULT. This check has priority over `Halt`.
  - Else if `Halt`=1, go to HALTED.
  - Else go to REQ.
- HALTED: `halted`=1, `inst_valid`=0, no requests. PC is frozen. The only exit is reset.
- FAULT: `fetch_fault`=1, `inst_valid`=0, no requests. PC holds the misaligned address. The only exit is reset.
- `PCincre` is always PC+4 with 32-bit wrap (32'hFFFF_FFFC → 0).
- `retire_count` wraps 32'hFFFF_FFFF → 0.

## Timing
- Reset values:
  - State = REQ; PC = `RESET_PC`; `PCincre` = `RESET_PC`+4.
  - `inst` = 32'h0000_0013 (NOP).
  - `inst_valid`, `halted`, `fetch_fault` = 0; `retire_count` = 0.
  - `imem_req_valid` is forced to 0 while `rst_n`=0.
- The first request is asserted in the first cycle after `rst_n` rises.
- Minimum 3 cycles per instruction, one each in REQ, WAIT and HOLD. The response arrives no earlier than the cycle after request acceptance.
- PC changes only on the clock edge that ends a retire cycle. `PCaddress` is stable for the entire REQ/WAIT/HOLD sequence of an instruction.
- Reset asserted mid-transaction (any state) aborts it immediately. A late `imem_resp_valid` after reset is ignored because the FSM is in REQ.
- `inst_ready` is don't-care outside HOLD.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum;
  - `NOP_INST` = 32'h0000_0013;
  - `PC_STEP` = 4.
- Single module with no sub-modules. The PC register, FSM, instruction latch and retire counter are all local.

## Test plan
- Reset with `RESET_PC`=32'h0000_1000, `imem_req_ready`=1 → cycle 1 after reset: `imem_req_valid`=1, `imem_addr`=32'h1000, `PCincre`=32'h1004, `inst`=NOP.
- Memory holds `imem_req_ready`=0 for 3 cycles, then responds with 32'h00500093 one cycle after acceptance → `imem_addr` is stable throughout, then `inst`=32'h00500093 with `inst_valid`=1.
- HOLD with `inst_ready` low for 4 cycles, then high with `PCnext`=32'h1010 → PC stays 32'h1000 for those cycles, then becomes 32'h1010; `retire_count`=1; next request is to 32'h1010.
- Retire with `Halt`=1 and `PCnext`=PC → HALTED: `halted`=1, no further `imem_req_valid`, PC unchanged for 20 cycles.
- Retire with `PCnext`=32'h1002 and `Halt`=1 → FAULT, not HALTED: `fetch_fault`=1, `PCaddress`=32'h1002, `halted`=0.
- Assert `rst_n`=0 during WAIT, then pulse `imem_resp_valid` after release → response ignored; fresh request to `RESET_PC`; `retire_count`=0.
